// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C register-bank target.
//   state_e    : protocol state machine encoding
//   BIT_ACK    : SDA level meaning acknowledge
//   BIT_NACK   : SDA level meaning not-acknowledge
//   REG_ADDR_W : register address width for a given bank size
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT
  } state_e;

  localparam logic BIT_ACK  = 1'b0;
  localparam logic BIT_NACK = 1'b1;

  function automatic int REG_ADDR_W(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/i2c_slave_filter.sv
// Two-flop synchroniser followed by a glitch filter for one bus line.
// The filtered level only moves after FILTER_LEN identical consecutive
// synchronised samples that differ from it; rise/fall pulse for one cycle
// in the cycle the new level first appears.
//   clk, rst : system clock, synchronous active-high reset
//   pin_i    : raw pin sense
//   level_o  : filtered level (resets to the idle-bus level 1)
//   rise_o   : one-cycle pulse, filtered level went 0->1
//   fall_o   : one-cycle pulse, filtered level went 1->0
module i2c_slave_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts how many samples in a row have disagreed with level_q;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a NUM_REGS x 8-bit register bank and auto-increment pointer.
// Write transfer: address(W), pointer byte, data bytes...
// Read transfer : address(R), data bytes from the current pointer.
//   clk, rst          : system clock, synchronous active-high reset
//   dev_address       : 7-bit address this target answers to
//   enable            : 0 = never acknowledge an address
//   scl_i/o/t         : SCL pin sense / drive (tied 1) / tristate (tied 1)
//   sda_i/o/t         : SDA pin sense / drive value / tristate (1 = released)
//   loc_addr          : local port register address
//   loc_wr_en/data    : local write strobe and data
//   loc_rd_data       : regs[loc_addr], one cycle latency
//   wr_valid/addr/data: one-cycle report of each I2C register write
//   busy              : set on address match, cleared by START or STOP
module i2c_slave_regs
  import i2c_slave_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [6:0]                      dev_address,
  input  logic                            enable,
  input  logic                            scl_i,
  output logic                            scl_o,
  output logic                            scl_t,
  input  logic                            sda_i,
  output logic                            sda_o,
  output logic                            sda_t,
  input  logic [REG_ADDR_W(NUM_REGS)-1:0] loc_addr,
  input  logic                            loc_wr_en,
  input  logic [7:0]                      loc_wr_data,
  output logic [7:0]                      loc_rd_data,
  output logic                            wr_valid,
  output logic [REG_ADDR_W(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                      wr_data,
  output logic                            busy
);

  localparam int AW = REG_ADDR_W(NUM_REGS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  state_e        state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          drive_q, drive_d;
  logic          busy_q, busy_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    loc_rd_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    byte_in;
  logic [7:0]    rd_byte;

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .pin_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_slave_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .pin_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign byte_in    = {shift_q[6:0], sda_lvl};
  assign rd_byte    = regs_q[ptr_q];

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    drive_d    = drive_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_cond) begin
      state_d  = S_ADDR;
      bitcnt_d = '0;
      drive_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_cond) begin
      state_d  = S_IDLE;
      bitcnt_d = '0;
      drive_d  = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d  = byte_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = '0;
              case (state_q)
                S_ADDR: begin
                  if (enable && (byte_in[7:1] == dev_address)) begin
                    state_d = S_ADDR_ACK;
                    busy_d  = 1'b1;
                    rw_d    = byte_in[0];
                  end else begin
                    state_d = S_WAIT;
                  end
                end
                S_PTR: begin
                  ptr_d   = byte_in[AW-1:0];
                  state_d = S_PTR_ACK;
                end
                default: begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = byte_in;
                  ptr_d      = ptr_q + 1'b1;
                  state_d    = S_WDATA_ACK;
                end
              endcase
            end
          end
        end

        // drive_q doubles as the ACK phase flag: it is always 0 on entry,
        // so the first falling edge starts the ACK and the second ends it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!drive_q) begin
              drive_d = 1'b1;
            end else begin
              drive_d = 1'b0;
              case (state_q)
                S_ADDR_ACK: begin
                  if (rw_q) begin
                    // First read bit goes out on the same edge that ends the ACK.
                    shift_d  = rd_byte;
                    ptr_d    = ptr_q + 1'b1;
                    drive_d  = ~rd_byte[7];
                    bitcnt_d = 4'd1;
                    state_d  = S_RDATA;
                  end else begin
                    state_d = S_PTR;
                  end
                end
                default: state_d = S_WDATA;
              endcase
            end
          end
        end

        // bitcnt_q = bits already placed on the bus; shift_q[7] is the bit
        // currently driven.
        S_RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 4'd0) begin
              drive_d  = ~shift_q[7];
              bitcnt_d = 4'd1;
            end else if (bitcnt_q == 4'd8) begin
              drive_d  = 1'b0;
              bitcnt_d = '0;
              state_d  = S_RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              drive_d  = ~shift_q[6];
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end
        end

        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == BIT_NACK) begin
              state_d = S_WAIT;
            end else begin
              shift_d  = rd_byte;
              ptr_d    = ptr_q + 1'b1;
              bitcnt_d = '0;
              state_d  = S_RDATA;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Local write is applied last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      loc_rd_q <= '0;
    end else begin
      if (wr_valid_d) regs_q[wr_addr_d] <= wr_data_d;
      if (loc_wr_en)  regs_q[loc_addr]  <= loc_wr_data;
      loc_rd_q <= regs_q[loc_addr];
    end
  end

  assign scl_o       = 1'b1;
  assign scl_t       = 1'b1;
  assign sda_o       = drive_q ? BIT_ACK : 1'b1;
  assign sda_t       = ~drive_q;
  assign loc_rd_data = loc_rd_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int NR = 16;

  logic       clk;
  logic       rst;
  logic [6:0] dev_address;
  logic       enable;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic [3:0] loc_addr;
  logic       loc_wr_en;
  logic [7:0] loc_wr_data;
  logic [7:0] loc_rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int Q = 10;
  int drv_cnt = 0;

  // Behavioural model of the register bank as seen by the bus.
  logic [7:0] mregs [NR];
  int         mptr;
  logic [7:0] wbuf [4];
  logic [3:0] exp_a[$], got_a[$];
  logic [7:0] exp_d[$], got_d[$];

  i2c_slave_regs #(.NUM_REGS(NR), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .dev_address(dev_address), .enable(enable),
    .scl_i(scl_i), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_i), .sda_o(sda_o), .sda_t(sda_t),
    .loc_addr(loc_addr), .loc_wr_en(loc_wr_en), .loc_wr_data(loc_wr_data),
    .loc_rd_data(loc_rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  // Open-drain wired-AND of master and target.
  assign scl_i = scl_m & (scl_t | scl_o);
  assign sda_i = sda_m & (sda_t | sda_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      got_a.push_back(wr_addr);
      got_d.push_back(wr_data);
    end
    if (sda_t === 1'b0) drv_cnt <= drv_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---- model ----
  task automatic m_ptr(input logic [7:0] p);
    mptr = p % NR;
  endtask

  task automatic m_wr(input logic [7:0] d);
    exp_a.push_back(4'(mptr));
    exp_d.push_back(d);
    mregs[mptr] = d;
    mptr = (mptr + 1) % NR;
  endtask

  task automatic m_rd(output logic [7:0] d);
    d = mregs[mptr];
    mptr = (mptr + 1) % NR;
  endtask

  // ---- bus master ----
  task automatic send_bit(input logic b);
    sda_m = b; cyc(Q); scl_m = 1'b1; cyc(Q); scl_m = 1'b0; cyc(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q / 2);
    b = sda_i;
    cyc(Q - Q / 2); scl_m = 1'b0; cyc(Q);
  endtask

  task automatic do_start();
    sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q); sda_m = 1'b0; cyc(Q); scl_m = 1'b0; cyc(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; cyc(Q); scl_m = 1'b1; cyc(Q); sda_m = 1'b1; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic i2c_wr(input string tag, input logic [7:0] p, input int n);
    logic a;
    do_start();
    send_byte(8'hAA, a); chk({tag, "_adr_ack"}, 32'(a), 0);
    send_byte(p, a);     chk({tag, "_ptr_ack"}, 32'(a), 0);
    m_ptr(p);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a); chk({tag, "_dat_ack"}, 32'(a), 0);
      m_wr(wbuf[i]);
    end
    do_stop(); cyc(4 * Q);
  endtask

  // Read n bytes from the current pointer (START acts as repeated START
  // when issued mid-transfer).
  task automatic i2c_rd_cur(input string tag, input int n);
    logic a;
    logic [7:0] d, e;
    do_start();
    send_byte(8'hAB, a); chk({tag, "_adr_ack"}, 32'(a), 0);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1), d);
      m_rd(e);
      chk({tag, "_rd"}, 32'(d), 32'(e));
    end
    do_stop(); cyc(4 * Q);
  endtask

  task automatic i2c_rd_at(input string tag, input logic [7:0] p, input int n);
    logic a;
    do_start();
    send_byte(8'hAA, a); chk({tag, "_adr_ack"}, 32'(a), 0);
    send_byte(p, a);     chk({tag, "_ptr_ack"}, 32'(a), 0);
    m_ptr(p);
    i2c_rd_cur(tag, n);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk({tag, "_wr_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
      chk({tag, "_wr_data"}, 32'(got_d[i]), 32'(exp_d[i]));
    end
    exp_a.delete(); exp_d.delete(); got_a.delete(); got_d.delete();
  endtask

  task automatic loc_wr(input logic [3:0] a, input logic [7:0] d);
    loc_addr = a; loc_wr_data = d; loc_wr_en = 1'b1; cyc(1); loc_wr_en = 1'b0;
    mregs[a] = d;
  endtask

  task automatic loc_chk(input string tag, input logic [3:0] a);
    loc_addr = a; cyc(1);
    chk(tag, 32'(loc_rd_data), 32'(mregs[a]));
  endtask

  initial begin
    logic a;
    int dc;
    int n;
    logic [7:0] p;
    rst = 1'b1; dev_address = 7'h55; enable = 1'b1;
    scl_m = 1'b1; sda_m = 1'b1;
    loc_addr = '0; loc_wr_en = 1'b0; loc_wr_data = '0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mptr = 0;
    cyc(5); rst = 1'b0; cyc(20);

    chk("rst_sda_t", 32'(sda_t), 1);
    chk("rst_sda_o", 32'(sda_o), 1);
    chk("rst_scl_t", 32'(scl_t), 1);
    chk("rst_scl_o", 32'(scl_o), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_loc_rd", 32'(loc_rd_data), 0);

    // Basic write burst
    do_start();
    send_byte(8'hAA, a); chk("t1_adr_ack", 32'(a), 0);
    chk("t1_busy", 32'(busy), 1);
    send_byte(8'h02, a); chk("t1_ptr_ack", 32'(a), 0); m_ptr(8'h02);
    send_byte(8'h3C, a); chk("t1_d0_ack", 32'(a), 0); m_wr(8'h3C);
    send_byte(8'h7E, a); chk("t1_d1_ack", 32'(a), 0); m_wr(8'h7E);
    do_stop(); cyc(20);
    chk("t1_busy_stop", 32'(busy), 0);
    check_writes("t1");
    loc_chk("t1_loc3", 4'd3);
    chk("t1_loc3_const", 32'(loc_rd_data), 32'h7E);

    // Wrong address, then disabled
    dc = drv_cnt;
    do_start();
    send_byte(8'hAC, a); chk("t2_nack", 32'(a), 1);
    chk("t2_busy", 32'(busy), 0);
    send_byte(8'h01, a); do_stop(); cyc(20);
    chk("t2_no_drive", 32'(drv_cnt - dc), 0);
    enable = 1'b0; dc = drv_cnt;
    do_start();
    send_byte(8'hAA, a); chk("t2e_nack", 32'(a), 1);
    chk("t2e_busy", 32'(busy), 0);
    send_byte(8'h01, a); do_stop(); cyc(20);
    chk("t2e_no_drive", 32'(drv_cnt - dc), 0);
    check_writes("t2");
    enable = 1'b1;

    // Pointer write, repeated START, 2-byte read, then pointer-less read
    do_start();
    send_byte(8'hAA, a); chk("t3_adr_ack", 32'(a), 0);
    send_byte(8'h03, a); chk("t3_ptr_ack", 32'(a), 0); m_ptr(8'h03);
    i2c_rd_cur("t3", 2);
    loc_wr(4'd5, 8'h5A);
    i2c_rd_cur("t3b", 1);
    check_writes("t3");

    // Pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    i2c_wr("t4", 8'h1F, 2);
    check_writes("t4");
    loc_chk("t4_loc15", 4'd15);
    loc_chk("t4_loc0", 4'd0);

    // Glitch rejection inside data byte 0x99
    do_start();
    send_byte(8'hAA, a); chk("t5_adr_ack", 32'(a), 0);
    send_byte(8'h06, a); chk("t5_ptr_ack", 32'(a), 0); m_ptr(8'h06);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q);
    scl_m = 1'b0; cyc(2); scl_m = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(3); sda_m = 1'b1; cyc(Q);
    scl_m = 1'b0; cyc(Q);
    chk("t5_busy_glitch", 32'(busy), 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    read_bit(a); chk("t5_dat_ack", 32'(a), 0); m_wr(8'h99);
    do_stop(); cyc(20);
    check_writes("t5");
    Q = 4;
    wbuf[0] = 8'hC3;
    i2c_wr("t5f", 8'h07, 1);
    Q = 10;
    check_writes("t5f");

    // Randomised write / read-back against the model
    for (int k = 0; k < 5; k++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      i2c_wr("rnd_w", p, n);
      check_writes("rnd_w");
      if ($urandom_range(0, 1) == 1) loc_wr(4'(p + 8'(n)), 8'($urandom));
      i2c_rd_at("rnd_r", p, n + 1);
    end
    check_writes("rnd_r");

    // STOP after a partial data byte
    do_start();
    send_byte(8'hAA, a); chk("t6a_adr_ack", 32'(a), 0);
    send_byte(8'h08, a); chk("t6a_ptr_ack", 32'(a), 0); m_ptr(8'h08);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    do_stop(); cyc(20);
    chk("t6a_busy", 32'(busy), 0);
    check_writes("t6a");
    loc_chk("t6a_loc8", 4'd8);
    i2c_rd_cur("t6a_rd", 1);

    // Reset while the target drives an ACK
    do_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hAA >> i) & 8'h01) != 0);
    for (int k = 0; k < 40 && sda_t !== 1'b0; k++) cyc(1);
    chk("t6b_ack_drv", 32'(sda_t), 0);
    rst = 1'b1; cyc(1);
    chk("t6b_sda_t", 32'(sda_t), 1);
    chk("t6b_sda_o", 32'(sda_o), 1);
    chk("t6b_busy", 32'(busy), 0);
    chk("t6b_wr_valid", 32'(wr_valid), 0);
    chk("t6b_wr_addr", 32'(wr_addr), 0);
    chk("t6b_wr_data", 32'(wr_data), 0);
    chk("t6b_loc_rd", 32'(loc_rd_data), 0);
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    loc_chk("t6b_reg3", 4'd3);
    loc_chk("t6b_reg15", 4'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
